// File: rtl/router_fifo.sv
// router_fifo
// -----------
// Output buffer for one destination port of the 1x3 router. Each stored
// entry is {header_marker, byte}. While the external reader drains a packet,
// a down-counter tracks how many payload and parity bytes remain after the
// header.
//
// Handshake semantics (both sides):
//   write side: a byte is accepted on a rising clk edge if and only if
//               write_enb is high and full is low in that cycle. A write
//               presented while full is dropped.
//   read side : a byte is consumed on a rising clk edge if and only if
//               read_enb is high and empty is low in that cycle. data_out
//               presents the byte from the following cycle and holds it
//               until the next accepted read.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   soft_reset  synchronous flush from the synchroniser timeout
//   write_enb   write request (this port's bit of the write_enb bus)
//   read_enb    read request from the external reader
//   lfd_state   high while data_in carries a packet header byte
//   data_in     byte to store
//   data_out    registered read data
//   full        no free entry
//   empty       no stored entry
//   pkt_active  header read out, remaining bytes of the packet not all read
module router_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             pkt_active
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  // Storage is intentionally not reset; the pointers alone define validity.
  logic [WIDTH:0]       mem_q [DEPTH];

  logic [ADDR_W:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]      rd_ptr_q, rd_ptr_d;
  logic [6:0]           count_q, count_d;
  logic [WIDTH-1:0]     data_out_q, data_out_d;

  logic                 do_wr;
  logic                 do_rd;
  logic                 flush;
  logic [WIDTH:0]       rd_entry;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  assign flush    = reset || soft_reset;
  assign do_wr    = write_enb && !full && !flush;
  assign do_rd    = read_enb && !empty && !flush;
  assign rd_entry = mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;

    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (do_rd) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = rd_entry[WIDTH-1:0];
      // A header byte carries the payload length in bits [7:2]; the extra
      // one accounts for the trailing parity byte.
      if (rd_entry[WIDTH]) begin
        count_d = {1'b0, rd_entry[7:2]} + 7'd1;
      end else if (count_q != 7'd0) begin
        count_d = count_q - 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= {lfd_state, data_in};
    end
  end

  assign data_out   = data_out_q;
  assign pkt_active = (count_q != 7'd0);

endmodule

// File: tb/tb_router_fifo.sv
module tb_router_fifo;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       pkt_active;

  always #5 clk = ~clk;

  router_fifo #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty),
    .pkt_active (pkt_active)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard of bytes expected to come out, oldest first.
  logic [7:0] exp_q[$];

  typedef struct {
    logic       rst;
    logic       srst;
    logic       wr;
    logic       rd;
    logic       lfd;
    logic [7:0] din;
    logic [7:0] e_dout;
    logic       e_full;
    logic       e_empty;
    logic       e_pkt;
  } vec_t;

  vec_t vecs[13];

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive inputs after a falling edge, let one rising edge occur, and
  // return at the next falling edge so outputs can be sampled safely.
  task automatic step(input logic rst, input logic srst, input logic wr,
                      input logic rd, input logic lfd, input logic [7:0] din);
    reset      = rst;
    soft_reset = srst;
    write_enb  = wr;
    read_enb   = rd;
    lfd_state  = lfd;
    data_in    = din;
    @(posedge clk);
    @(negedge clk);
    reset      = 1'b0;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    data_in    = 8'h00;
  endtask

  task automatic write_byte(input logic [7:0] b);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, b);
    exp_q.push_back(b);
  endtask

  task automatic read_check(input string tag);
    logic [7:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check($sformatf("%s data_out", tag), {24'd0, data_out}, {24'd0, e});
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b0;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    data_in    = 8'h00;

    //               rst  srst wr   rd   lfd  din    dout   full empty pkt
    vecs[0]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,8'h55, 8'h00,1'b0,1'b1,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h00,1'b0,1'b1,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,8'h0C, 8'h00,1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,8'h11, 8'h00,1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,8'h22, 8'h00,1'b0,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,8'h33, 8'h00,1'b0,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,8'h44, 8'h00,1'b0,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h0C,1'b0,1'b0,1'b1};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h11,1'b0,1'b0,1'b1};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h22,1'b0,1'b0,1'b1};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h33,1'b0,1'b0,1'b1};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h44,1'b0,1'b1,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h44,1'b0,1'b1,1'b0};

    @(negedge clk);

    // Table: reset with write pending, then one packet in and out.
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst, vecs[i].srst, vecs[i].wr, vecs[i].rd, vecs[i].lfd, vecs[i].din);
      check($sformatf("vec%0d data_out", i), {24'd0, data_out}, {24'd0, vecs[i].e_dout});
      check($sformatf("vec%0d full", i), {31'd0, full}, {31'd0, vecs[i].e_full});
      check($sformatf("vec%0d empty", i), {31'd0, empty}, {31'd0, vecs[i].e_empty});
      check($sformatf("vec%0d pkt_active", i), {31'd0, pkt_active}, {31'd0, vecs[i].e_pkt});
    end

    // Full boundary: 16 writes fill, 17th dropped.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      write_byte(i[7:0]);
      check($sformatf("fill%0d full", i), {31'd0, full}, {31'd0, (i == 15)});
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    check("overflow full", {31'd0, full}, 32'd1);
    for (int i = 0; i < 16; i++) read_check($sformatf("drain%0d", i));
    check("drain empty", {31'd0, empty}, 32'd1);
    check("drain full", {31'd0, full}, 32'd0);

    // Simultaneous read/write at full, then below full.
    do_reset();
    for (int i = 0; i < 16; i++) write_byte(8'h30 + i[7:0]);
    check("sim pre full", {31'd0, full}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hAA);
    check("sim@full data_out", {24'd0, data_out}, 32'h30);
    check("sim@full full", {31'd0, full}, 32'd0);
    void'(exp_q.pop_front());
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hBB);
    check("sim data_out", {24'd0, data_out}, 32'h31);
    check("sim full", {31'd0, full}, 32'd0);
    void'(exp_q.pop_front());
    exp_q.push_back(8'hBB);
    write_byte(8'hCC);
    check("sim occupancy full", {31'd0, full}, 32'd1);
    for (int i = 0; i < 16; i++) read_check($sformatf("sim drain%0d", i));
    check("sim drain empty", {31'd0, empty}, 32'd1);

    // Wrap-around: pointers cross the end of the array.
    do_reset();
    for (int i = 0; i < 10; i++) write_byte(8'h80 + i[7:0]);
    for (int i = 0; i < 10; i++) read_check($sformatf("wrapA%0d", i));
    for (int i = 0; i < 16; i++) write_byte(8'hC0 ^ (i[7:0] * 8'd7));
    check("wrap full", {31'd0, full}, 32'd1);
    for (int i = 0; i < 16; i++) read_check($sformatf("wrapB%0d", i));
    check("wrap empty", {31'd0, empty}, 32'd1);

    // Soft reset in the middle of a packet.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h08);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h03);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("sr hdr data_out", {24'd0, data_out}, 32'h08);
    check("sr hdr pkt_active", {31'd0, pkt_active}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("sr pay data_out", {24'd0, data_out}, 32'h01);
    check("sr pay pkt_active", {31'd0, pkt_active}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h77);
    check("sr empty", {31'd0, empty}, 32'd1);
    check("sr full", {31'd0, full}, 32'd0);
    check("sr pkt_active", {31'd0, pkt_active}, 32'd0);
    check("sr data_out", {24'd0, data_out}, 32'h00);
    exp_q.delete();
    write_byte(8'h5A);
    check("sr post-write empty", {31'd0, empty}, 32'd0);
    read_check("sr post");
    check("sr post empty", {31'd0, empty}, 32'd1);
    check("sr post pkt_active", {31'd0, pkt_active}, 32'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
